// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction-memory request/response,
// processor-side valid/ready handshake, branch redirect and halt status.
interface instruction_fetch_unit_if;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPC;
    logic        instReady;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        halted;

    modport master (
        output imemReqValid, imemReqAddr,
        input  imemReqReady, imemRespValid, imemRespData,
        output instValid, instData, instPC,
        input  instReady, redirectValid, redirectPC,
        output halted
    );

    modport slave (
        input  imemReqValid, imemReqAddr,
        output imemReqReady, imemRespValid, imemRespData,
        input  instValid, instData, instPC,
        output instReady, redirectValid, redirectPC,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch with credit-limited prefetch FIFO, redirect flush
// and stale-response discard. Halt-word detection is enabled by IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    instruction_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
`ifdef IFU_HALT_DETECT_EN
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
`endif

    typedef enum logic {RUN, HALT} state_t;

    state_t        state_reg, state_next;
    logic          running_reg;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0] pcq_wr_reg, pcq_rd_reg;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];
    logic [31:0] pcq_mem  [FIFO_DEPTH];

    logic req_valid, req_fire, resp_fire, resp_keep, pop, halt_hit, redirect;
    logic inst_valid;
    logic [1:0] unused_redirect_bits;

    assign unused_redirect_bits = bus.redirectPC[1:0];
    assign redirect   = bus.redirectValid;
    assign inst_valid = (count_reg != '0);

    always_comb begin
        // Credits cover both outstanding requests and buffered words, so a
        // response can never arrive to a full FIFO.
        req_valid = running_reg && (state_reg == RUN) &&
                    (({1'b0, inflight_reg} + {1'b0, count_reg}) < DEPTH_EXT);
        req_fire  = req_valid && bus.imemReqReady;
        resp_fire = bus.imemRespValid && (inflight_reg != '0);
        resp_keep = resp_fire && (discard_reg == '0) && !redirect;
        pop       = inst_valid && bus.instReady && !redirect;
`ifdef IFU_HALT_DETECT_EN
        halt_hit  = resp_keep && (bus.imemRespData == HALT_WORD);
`else
        halt_hit  = 1'b0;
`endif
    end

    always_comb begin
        inflight_next = inflight_reg + CW'(req_fire) - CW'(resp_fire);

        // Everything still outstanding after a redirect or a halt is stale.
        discard_next = discard_reg;
        if (redirect || halt_hit) begin
            discard_next = inflight_next;
        end else if (resp_fire && (discard_reg != '0)) begin
            discard_next = discard_reg - CW'(1);
        end

        count_next = count_reg;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(resp_keep) - CW'(pop);
        end

        fetch_pc_next = fetch_pc_reg;
        if (redirect) begin
            fetch_pc_next = {bus.redirectPC[31:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end

        state_next = state_reg;
        if (redirect) begin
            state_next = RUN;
        end else if (halt_hit) begin
            state_next = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            running_reg  <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            inflight_reg <= '0;
            discard_reg  <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pcq_wr_reg   <= '0;
            pcq_rd_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            running_reg  <= 1'b1;
            fetch_pc_reg <= fetch_pc_next;
            inflight_reg <= inflight_next;
            discard_reg  <= discard_next;
            count_reg    <= count_next;
            if (redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (resp_keep) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)       rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            // The PC queue tracks every accepted request, stale or not, so its
            // head always pairs with the next response.
            if (req_fire)  pcq_wr_reg <= pcq_wr_reg + PW'(1);
            if (resp_fire) pcq_rd_reg <= pcq_rd_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resp_keep) begin
            data_mem[wr_ptr_reg] <= bus.imemRespData;
            pc_mem[wr_ptr_reg]   <= pcq_mem[pcq_rd_reg];
        end
        if (req_fire) begin
            pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
        end
    end

    assign bus.imemReqValid = req_valid;
    assign bus.imemReqAddr  = fetch_pc_reg;
    assign bus.instValid    = inst_valid;
    assign bus.instData     = inst_valid ? data_mem[rd_ptr_reg] : 32'd0;
    assign bus.instPC       = inst_valid ? pc_mem[rd_ptr_reg]   : 32'd0;
`ifdef IFU_HALT_DETECT_EN
    assign bus.halted       = (state_reg == HALT);
`else
    assign bus.halted       = 1'b0;
`endif
endmodule
